fcsr_unit: RTL and testbench
============================

FCSR_UNIT -- requirements
Module: fcsr_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): PARM_RM, 3, rounding-mode width; PARM_XLEN, 32, CSR data width; PARM_MAX_OUT, 4, maximum in-flight MAC operations; PARM_RM_RNE..PARM_RM_RMM, 3'b000..3'b100, static rounding encodings; PARM_RM_DYN, 3'b111, use frm.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
op_valid_i  in  1  FMA op request
op_rm_i  in  PARM_RM  instruction rm field
op_ready_o  out  1  op accepted when valid&ready
mac_valid_o  out  1  one-cycle issue pulse to the MAC
Rounding_mode_o  out  PARM_RM  resolved rounding mode for the MAC Rounding_mode_i
illegal_rm_o  out  1  one-cycle pulse: accepted op had an illegal rm
mac_done_i  in  1  MAC result/flags valid
NV_i, OF_i, UF_i, NX_i  in  1 each  MAC exception flags, qualified by mac_done_i
csr_req_i  in  1  CSR access request, held until ack
csr_op_i  in  2  01 RW, 10 RS, 11 RC, 00 treated as RS
csr_addr_i  in  12  0x001 fflags, 0x002 frm, 0x003 fcsr
csr_wdata_i  in  PARM_XLEN  write/set/clear operand
csr_rdata_o  out  PARM_XLEN  old CSR value, valid with ack
csr_ack_o  out  1  one-cycle completion pulse

Function
REQ-003 The state SHALL be fflags[4:0]={NV,DZ,OF,UF,NX}, frm[2:0], outstanding counter [0..PARM_MAX_OUT], and FSM {IDLE, DRAIN, EXEC}.
REQ-004 op_ready_o SHALL be 1 only when FSM=IDLE, csr_req_i=0, and counter<PARM_MAX_OUT or mac_done_i=1.
REQ-005 The resolved rm SHALL be op_rm_i, or frm when op_rm_i=3'b111; resolved values 101/110/111 SHALL be illegal.
REQ-006 An accepted legal op SHALL assert mac_valid_o for exactly one cycle, the cycle after acceptance, with Rounding_mode_o holding the resolved rm; Rounding_mode_o SHALL hold its last value otherwise.
REQ-007 An accepted illegal op SHALL pulse illegal_rm_o the cycle after acceptance, SHALL NOT pulse mac_valid_o, and SHALL NOT change the counter.
REQ-008 The counter SHALL be +1 on a legal accept, -1 on mac_done_i, and unchanged when both occur in the same cycle.
REQ-009 When counter=0, mac_done_i SHALL be ignored: no decrement and no flag accrual.
REQ-010 When mac_done_i=1 and counter>0, fflags SHALL OR in {NV_i,1'b0,OF_i,UF_i,NX_i}; DZ SHALL be set only by CSR writes.
REQ-011 In IDLE, csr_req_i=1 SHALL move the FSM to EXEC if counter=0, or to DRAIN otherwise.
REQ-012 DRAIN SHALL keep accruing done flags and SHALL move to EXEC in the cycle after the counter reaches 0.
REQ-013 In EXEC, csr_ack_o SHALL be 1 and csr_rdata_o SHALL be the pre-write value: fflags zero-extended, frm zero-extended, or fcsr={24'b0,frm,fflags}.
REQ-014 The write SHALL commit at the edge ending EXEC: RW new=wdata, RS old|wdata, RC old&~wdata, masked to the field width; fcsr SHALL update both fields.
REQ-015 After EXEC, the FSM SHALL return to IDLE.
REQ-016 For an unknown address, EXEC SHALL ack with rdata 0 and SHALL write nothing.
REQ-017 Outside EXEC, csr_rdata_o SHALL be 0 and csr_ack_o SHALL be 0.
REQ-018 The requester SHALL drop csr_req_i the cycle after ack; a request held beyond that SHALL start a new access.

Reset
REQ-019 Asserting rst at any time SHALL immediately clear fflags and counter, set frm to 000, set the FSM to IDLE, and drive all outputs (including Rounding_mode_o) to 0.
REQ-020 In-flight ops at reset SHALL be forgotten; their later mac_done_i pulses SHALL be ignored per REQ-009.

Verification
REQ-021 Reset, then RS of fcsr with wdata 0 -> ack one cycle after req, rdata 0x00000000, no state change.
REQ-022 RW frm=3'b011, then op rm=111 -> mac_valid_o the next cycle with Rounding_mode_o=011 and counter=1.
REQ-023 Two ops, done with NV=1, then done with NX=1, then read fcsr -> rdata 0x00000071 and counter 0.
REQ-024 CSR req with 2 outstanding -> FSM in DRAIN and no ack until both dones; ack the cycle after the counter reaches 0; op_ready_o low throughout.
REQ-025 frm=101, op rm=111 -> illegal_rm_o pulse and no mac_valid_o; op rm=110 -> same response.
REQ-026 Four ops fill the counter (op_ready_o=0); a new op in the same cycle as mac_done_i -> accepted and counter stays 4; rst mid-DRAIN -> IDLE with counter 0.

Source files
------------

// File: rtl/fcsr_unit_if.sv
// FP CSR unit bus: FMA op issue, MAC completion/flags and CSR access.
interface fcsr_unit_if #(
   parameter int PARM_RM   = 3,
   parameter int PARM_XLEN = 32
);
   logic                 op_valid_i;
   logic [PARM_RM-1:0]   op_rm_i;
   logic                 op_ready_o;
   logic                 mac_valid_o;
   logic [PARM_RM-1:0]   Rounding_mode_o;
   logic                 illegal_rm_o;
   logic                 mac_done_i;
   logic                 NV_i;
   logic                 OF_i;
   logic                 UF_i;
   logic                 NX_i;
   logic                 csr_req_i;
   logic [1:0]           csr_op_i;
   logic [11:0]          csr_addr_i;
   logic [PARM_XLEN-1:0] csr_wdata_i;
   logic [PARM_XLEN-1:0] csr_rdata_o;
   logic                 csr_ack_o;

   // Requester / environment side
   modport master (
      output op_valid_i, op_rm_i, mac_done_i, NV_i, OF_i, UF_i, NX_i,
             csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
      input  op_ready_o, mac_valid_o, Rounding_mode_o, illegal_rm_o,
             csr_rdata_o, csr_ack_o
   );

   // fcsr_unit side
   modport slave (
      input  op_valid_i, op_rm_i, mac_done_i, NV_i, OF_i, UF_i, NX_i,
             csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
      output op_ready_o, mac_valid_o, Rounding_mode_o, illegal_rm_o,
             csr_rdata_o, csr_ack_o
   );
endinterface

// File: rtl/fcsr_unit.sv
// Floating-point CSR unit: holds fflags/frm, resolves rounding modes for
// FMA issue, tracks outstanding MAC ops and serialises CSR accesses
// behind them so reads see fully accrued flags.
module fcsr_unit #(
   parameter int               PARM_RM      = 3,
   parameter int               PARM_XLEN    = 32,
   parameter int               PARM_MAX_OUT = 4,
   parameter logic [PARM_RM-1:0] PARM_RM_RNE = 3'b000,
   parameter logic [PARM_RM-1:0] PARM_RM_RTZ = 3'b001,
   parameter logic [PARM_RM-1:0] PARM_RM_RDN = 3'b010,
   parameter logic [PARM_RM-1:0] PARM_RM_RUP = 3'b011,
   parameter logic [PARM_RM-1:0] PARM_RM_RMM = 3'b100,
   parameter logic [PARM_RM-1:0] PARM_RM_DYN = 3'b111
) (
   input logic        clk,
   input logic        rst,
   fcsr_unit_if.slave bus
);

   localparam int unsigned CW = $clog2(PARM_MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(PARM_MAX_OUT);

   typedef enum logic [1:0] {IDLE, DRAIN, EXEC} state_t;

   state_t               state;
   logic [4:0]           fflags;
   logic [2:0]           frm;
   logic [CW-1:0]        count;

   logic                 ready;
   logic                 accept;
   logic                 legal;
   logic                 inc;
   logic                 done_ok;
   logic [PARM_RM-1:0]   rm_res;
   logic [7:0]           old8;
   logic [7:0]           new8;
   logic                 addr_ok;
   logic [4:0]           wr_ff;
   logic [2:0]           wr_frm;
   logic [PARM_XLEN-1:0] rd_val;

   // Op acceptance, rounding-mode resolution and done qualification
   always_comb begin
      ready   = !rst && (state == IDLE) && !bus.csr_req_i &&
                ((count < MAX_CNT) || bus.mac_done_i);
      accept  = bus.op_valid_i && ready;
      rm_res  = (bus.op_rm_i == PARM_RM_DYN) ? PARM_RM'(frm) : bus.op_rm_i;
      legal   = rm_res inside {PARM_RM_RNE, PARM_RM_RTZ, PARM_RM_RDN,
                               PARM_RM_RUP, PARM_RM_RMM};
      inc     = accept && legal;
      done_ok = bus.mac_done_i && (count != '0);
   end

   assign bus.op_ready_o = ready;

   // CSR read value and post-write field values; frm sits in the low bits
   // of old8 for the frm address so one RW/RS/RC path serves all fields
   always_comb begin
      old8    = {frm, fflags};
      addr_ok = 1'b1;
      case (bus.csr_addr_i)
         12'h001: old8 = {3'b000, fflags};
         12'h002: old8 = {5'b00000, frm};
         12'h003: old8 = {frm, fflags};
         default: addr_ok = 1'b0;
      endcase
      case (bus.csr_op_i)
         2'b01:   new8 = bus.csr_wdata_i[7:0];
         2'b11:   new8 = old8 & ~bus.csr_wdata_i[7:0];
         default: new8 = old8 | bus.csr_wdata_i[7:0];
      endcase
      wr_ff  = fflags;
      wr_frm = frm;
      case (bus.csr_addr_i)
         12'h001: wr_ff = new8[4:0];
         12'h002: wr_frm = new8[2:0];
         12'h003: begin
            wr_ff  = new8[4:0];
            wr_frm = new8[7:5];
         end
         default: ;
      endcase
      rd_val = addr_ok ? PARM_XLEN'(old8) : '0;
   end

   // Control FSM with CSR state, flag accrual and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         fflags              <= '0;
         frm                 <= '0;
         bus.mac_valid_o     <= 1'b0;
         bus.Rounding_mode_o <= '0;
         bus.illegal_rm_o    <= 1'b0;
         bus.csr_ack_o       <= 1'b0;
         bus.csr_rdata_o     <= '0;
      end else begin
         bus.mac_valid_o  <= inc;
         bus.illegal_rm_o <= accept && !legal;
         if (inc) bus.Rounding_mode_o <= rm_res;
         bus.csr_ack_o    <= 1'b0;
         bus.csr_rdata_o  <= '0;
         if (done_ok) fflags <= fflags | {bus.NV_i, 1'b0, bus.OF_i, bus.UF_i, bus.NX_i};
         case (state)
            IDLE: begin
               if (bus.csr_req_i) begin
                  if (count == '0) begin
                     state           <= EXEC;
                     bus.csr_ack_o   <= 1'b1;
                     bus.csr_rdata_o <= rd_val;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (count == '0) begin
                  state           <= EXEC;
                  bus.csr_ack_o   <= 1'b1;
                  bus.csr_rdata_o <= rd_val;
               end
            end
            EXEC: begin
               fflags <= wr_ff;
               frm    <= wr_frm;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outstanding MAC operation counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({inc, done_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fcsr_unit.sv
// Directed self-checking bench for fcsr_unit.
module tb_fcsr_unit;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fcsr_unit_if #(.PARM_RM(3), .PARM_XLEN(32)) bus();

   fcsr_unit #(.PARM_RM(3), .PARM_XLEN(32), .PARM_MAX_OUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_op(input logic [2:0] rm);
      bus.op_valid_i = 1'b1;
      bus.op_rm_i    = rm;
      tick();
      bus.op_valid_i = 1'b0;
   endtask

   task automatic done_pulse(input logic nv, input logic of_f, input logic uf, input logic nx);
      bus.mac_done_i = 1'b1;
      bus.NV_i = nv; bus.OF_i = of_f; bus.UF_i = uf; bus.NX_i = nx;
      tick();
      bus.mac_done_i = 1'b0;
      bus.NV_i = 1'b0; bus.OF_i = 1'b0; bus.UF_i = 1'b0; bus.NX_i = 1'b0;
   endtask

   task automatic csr_access(input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd, output int lat);
      bus.csr_req_i   = 1'b1;
      bus.csr_op_i    = op;
      bus.csr_addr_i  = addr;
      bus.csr_wdata_i = wd;
      lat = 0;
      repeat (50) begin
         tick();
         lat++;
         if (bus.csr_ack_o === 1'b1) break;
      end
      checks++;
      if (bus.csr_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL csr_ack_timeout: ack=%b required 1 addr=%h", bus.csr_ack_o, addr);
      end
      rd = bus.csr_rdata_o;
      tick();
      bus.csr_req_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.op_valid_i = 0; bus.op_rm_i = 0; bus.mac_done_i = 0;
      bus.NV_i = 0; bus.OF_i = 0; bus.UF_i = 0; bus.NX_i = 0;
      bus.csr_req_i = 0; bus.csr_op_i = 0; bus.csr_addr_i = 0; bus.csr_wdata_i = 0;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.op_ready_o, bus.mac_valid_o, bus.illegal_rm_o, bus.csr_ack_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000",
                  {bus.op_ready_o, bus.mac_valid_o, bus.illegal_rm_o, bus.csr_ack_o});
      end
      checks++;
      if (bus.Rounding_mode_o !== 3'd0 || bus.csr_rdata_o !== 32'd0 || dut.count !== 3'd0) begin
         errors++;
         $display("FAIL reset_data: rm=%h rdata=%h count=%0d required 0/0/0",
                  bus.Rounding_mode_o, bus.csr_rdata_o, dut.count);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.op_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b required 1", bus.op_ready_o);
      end
      tick();
   endtask

   task automatic test_rs_zero();
      logic [31:0] rd;
      int lat;
      csr_access(2'b10, 12'h003, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h0 || lat != 1) begin
         errors++;
         $display("FAIL rs_fcsr_zero: rdata=%h lat=%0d required 00000000 lat=1", rd, lat);
      end
      checks++;
      if (bus.csr_ack_o !== 1'b0 || bus.csr_rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL ack_one_cycle: ack=%b rdata=%h required 0/0", bus.csr_ack_o, bus.csr_rdata_o);
      end
      csr_access(2'b10, 12'h003, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL rs_no_change: rdata=%h required 00000000", rd);
      end
   endtask

   task automatic test_dyn_rm();
      logic [31:0] rd;
      int lat;
      csr_access(2'b01, 12'h002, 32'h3, rd, lat);
      issue_op(3'b111);
      checks++;
      if (bus.mac_valid_o !== 1'b1 || bus.Rounding_mode_o !== 3'b011 || dut.count !== 3'd1) begin
         errors++;
         $display("FAIL dyn_issue: valid=%b rm=%b count=%0d required 1/011/1",
                  bus.mac_valid_o, bus.Rounding_mode_o, dut.count);
      end
      tick();
      checks++;
      if (bus.mac_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL mac_valid_pulse: got %b required 0", bus.mac_valid_o);
      end
      done_pulse(0, 0, 0, 0);
      checks++;
      if (dut.count !== 3'd0) begin
         errors++;
         $display("FAIL dyn_drain: count=%0d required 0", dut.count);
      end
   endtask

   task automatic test_flags();
      logic [31:0] rd;
      int lat;
      issue_op(3'b000);
      issue_op(3'b000);
      checks++;
      if (dut.count !== 3'd2) begin
         errors++;
         $display("FAIL two_ops: count=%0d required 2", dut.count);
      end
      done_pulse(1, 0, 0, 0);
      done_pulse(0, 0, 0, 1);
      checks++;
      if (dut.count !== 3'd0) begin
         errors++;
         $display("FAIL flags_drain: count=%0d required 0", dut.count);
      end
      csr_access(2'b10, 12'h003, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h0000_0071) begin
         errors++;
         $display("FAIL fcsr_accrued: rdata=%h required 00000071", rd);
      end
   endtask

   task automatic test_drain();
      logic [31:0] rd;
      int lat;
      issue_op(3'b100);
      issue_op(3'b100);
      bus.csr_req_i = 1'b1; bus.csr_op_i = 2'b11; bus.csr_addr_i = 12'h003; bus.csr_wdata_i = 32'h1F;
      #1;
      checks++;
      if (bus.op_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_ready_req: got %b required 0", bus.op_ready_o);
      end
      tick();
      checks++;
      if (dut.state !== 2'd1 || bus.csr_ack_o !== 1'b0 || bus.op_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_enter: state=%0d ack=%b ready=%b required 1/0/0",
                  dut.state, bus.csr_ack_o, bus.op_ready_o);
      end
      tick();
      bus.mac_done_i = 1'b1;
      #1;
      checks++;
      if (bus.op_ready_o !== 1'b0 || bus.csr_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_hold: ready=%b ack=%b required 0/0", bus.op_ready_o, bus.csr_ack_o);
      end
      tick();
      tick();
      bus.mac_done_i = 1'b0;
      checks++;
      if (dut.count !== 3'd0 || bus.csr_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_zero: count=%0d ack=%b required 0/0", dut.count, bus.csr_ack_o);
      end
      tick();
      checks++;
      if (bus.csr_ack_o !== 1'b1 || bus.csr_rdata_o !== 32'h71 || bus.op_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_ack: ack=%b rdata=%h ready=%b required 1/00000071/0",
                  bus.csr_ack_o, bus.csr_rdata_o, bus.op_ready_o);
      end
      tick();
      bus.csr_req_i = 1'b0;
      csr_access(2'b10, 12'h003, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h0000_0060) begin
         errors++;
         $display("FAIL rc_fcsr: rdata=%h required 00000060", rd);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] rd;
      int lat;
      csr_access(2'b01, 12'h002, 32'h5, rd, lat);
      issue_op(3'b111);
      checks++;
      if (bus.illegal_rm_o !== 1'b1 || bus.mac_valid_o !== 1'b0 || dut.count !== 3'd0 ||
          bus.Rounding_mode_o !== 3'b100) begin
         errors++;
         $display("FAIL illegal_dyn: ill=%b valid=%b count=%0d rm=%b required 1/0/0/100",
                  bus.illegal_rm_o, bus.mac_valid_o, dut.count, bus.Rounding_mode_o);
      end
      tick();
      checks++;
      if (bus.illegal_rm_o !== 1'b0) begin
         errors++;
         $display("FAIL illegal_pulse: got %b required 0", bus.illegal_rm_o);
      end
      issue_op(3'b110);
      checks++;
      if (bus.illegal_rm_o !== 1'b1 || bus.mac_valid_o !== 1'b0 || dut.count !== 3'd0) begin
         errors++;
         $display("FAIL illegal_110: ill=%b valid=%b count=%0d required 1/0/0",
                  bus.illegal_rm_o, bus.mac_valid_o, dut.count);
      end
   endtask

   task automatic test_unknown_addr();
      logic [31:0] rd;
      int lat;
      csr_access(2'b01, 12'h7FF, 32'hFFFF_FFFF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL unknown_rdata: rdata=%h required 00000000", rd);
      end
      csr_access(2'b10, 12'h003, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h0000_00A0) begin
         errors++;
         $display("FAIL unknown_nowrite: rdata=%h required 000000a0", rd);
      end
   endtask

   task automatic test_back_to_back();
      bus.csr_req_i = 1'b1; bus.csr_op_i = 2'b10; bus.csr_addr_i = 12'h002; bus.csr_wdata_i = 32'h0;
      tick();
      checks++;
      if (bus.csr_ack_o !== 1'b1 || bus.csr_rdata_o !== 32'h5) begin
         errors++;
         $display("FAIL b2b_first: ack=%b rdata=%h required 1/00000005", bus.csr_ack_o, bus.csr_rdata_o);
      end
      tick();
      checks++;
      if (bus.csr_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: ack=%b required 0", bus.csr_ack_o);
      end
      tick();
      bus.csr_req_i = 1'b0;
      checks++;
      if (bus.csr_ack_o !== 1'b1 || bus.csr_rdata_o !== 32'h5) begin
         errors++;
         $display("FAIL b2b_second: ack=%b rdata=%h required 1/00000005", bus.csr_ack_o, bus.csr_rdata_o);
      end
      tick();
   endtask

   task automatic test_full_and_reset();
      logic [31:0] rd;
      int lat;
      csr_access(2'b01, 12'h002, 32'h0, rd, lat);
      repeat (4) issue_op(3'b010);
      #1;
      checks++;
      if (dut.count !== 3'd4 || bus.op_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL full: count=%0d ready=%b required 4/0", dut.count, bus.op_ready_o);
      end
      bus.op_valid_i = 1'b1; bus.op_rm_i = 3'b001; bus.mac_done_i = 1'b1;
      #1;
      checks++;
      if (bus.op_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL full_done_ready: got %b required 1", bus.op_ready_o);
      end
      tick();
      bus.op_valid_i = 1'b0; bus.mac_done_i = 1'b0;
      checks++;
      if (bus.mac_valid_o !== 1'b1 || bus.Rounding_mode_o !== 3'b001 || dut.count !== 3'd4) begin
         errors++;
         $display("FAIL full_swap: valid=%b rm=%b count=%0d required 1/001/4",
                  bus.mac_valid_o, bus.Rounding_mode_o, dut.count);
      end
      bus.csr_req_i = 1'b1; bus.csr_op_i = 2'b10; bus.csr_addr_i = 12'h003; bus.csr_wdata_i = 32'h0;
      tick();
      done_pulse(0, 0, 0, 0);
      checks++;
      if (dut.state !== 2'd1 || dut.count !== 3'd3) begin
         errors++;
         $display("FAIL mid_drain: state=%0d count=%0d required 1/3", dut.state, dut.count);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (dut.count !== 3'd0 || dut.state !== 2'd0 || bus.Rounding_mode_o !== 3'd0 ||
          bus.op_ready_o !== 1'b0 || bus.csr_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_drain: count=%0d state=%0d rm=%b ready=%b ack=%b required 0/0/000/0/0",
                  dut.count, dut.state, bus.Rounding_mode_o, bus.op_ready_o, bus.csr_ack_o);
      end
      tick();
      rst = 1'b0;
      bus.csr_req_i = 1'b0;
      tick();
      done_pulse(1, 1, 1, 1);
      checks++;
      if (dut.count !== 3'd0) begin
         errors++;
         $display("FAIL late_done: count=%0d required 0", dut.count);
      end
      csr_access(2'b10, 12'h003, 32'h0, rd, lat);
      checks++;
      if (rd !== 32'h0 || lat != 1) begin
         errors++;
         $display("FAIL post_reset_fcsr: rdata=%h lat=%0d required 00000000 lat=1", rd, lat);
      end
   endtask

   initial begin
      test_reset();
      test_rs_zero();
      test_dyn_rm();
      test_flags();
      test_drain();
      test_illegal();
      test_unknown_addr();
      test_back_to_back();
      test_full_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
